// File: rtl/onehot_to_binary_pipe.sv
// rtl/onehot_to_binary_pipe.sv - one-hot to binary decoder with one ready/valid output stage
// Flags all-zero or multi-hot words and counts accepted illegal words in a saturating counter.
module onehot_to_binary_pipe #(
    parameter int input_width = 4,
    parameter int count_width = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2**input_width-1:0]   onehot_input,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [input_width-1:0]      binary_output,
    output logic                        onehot_error,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [count_width-1:0]      error_count,
    input  logic                        clear_count
);

    localparam int onehot_width = 2**input_width;
    localparam logic [onehot_width-1:0] one_c = {{(onehot_width-1){1'b0}}, 1'b1};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [input_width-1:0]   bin_q, bin_d;
    logic                     err_q, err_d;
    logic [count_width-1:0]   cnt_q, cnt_d;

    logic [input_width-1:0]   dec_idx;
    logic                     dec_illegal;
    logic                     in_xfer;
    logic                     out_xfer;

    // Downward scan so the last assignment wins: lowest set bit for multi-hot words.
    always_comb begin
        dec_idx = '0;
        for (int i = onehot_width - 1; i >= 0; i--) begin
            if (onehot_input[i]) begin
                dec_idx = input_width'(i);
            end
        end
        dec_illegal = (onehot_input == '0) || ((onehot_input & (onehot_input - one_c)) != '0);
    end

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = (state_q == FULL) && out_ready;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_xfer && !in_xfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (in_xfer) begin
            bin_d = dec_idx;
            err_d = dec_illegal;
        end
    end

    // Clear has priority, so an illegal word accepted on the clearing edge is not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (in_xfer && dec_illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            bin_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = (state_q == FULL);
    assign binary_output = bin_q;
    assign onehot_error  = err_q;
    assign error_count   = cnt_q;

endmodule

// File: doc/onehot_to_binary_pipe.md
ONEHOT_TO_BINARY_PIPE -- requirements
Module: onehot_to_binary_pipe

Interface
REQ-001 Parameter: input_width, default 4, binary code width; one-hot width is 2**input_width.
REQ-002 Parameter: count_width, default 8, width of error counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 onehot_input  input  2**input_width  one-hot code word from upstream binary_to_onehot stage.
REQ-007 in_valid  input  1  onehot_input valid.
REQ-008 in_ready  output  1  block can accept onehot_input this cycle.
REQ-009 binary_output  output  input_width  decoded index.
REQ-010 onehot_error  output  1  qualifies binary_output: source word was all-zero or multi-hot.
REQ-011 out_valid  output  1  binary_output/onehot_error valid.
REQ-012 out_ready  input  1  downstream accepts output this cycle.
REQ-013 error_count  output  count_width  accepted illegal words since last clear/reset, saturating.
REQ-014 clear_count  input  1  synchronous clear of error_count.

Function
REQ-015 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational; single output register stage, no bubble under continuous flow).
REQ-017 Latency SHALL be exactly 1 cycle: a word accepted at edge N appears with out_valid=1 after edge N.
REQ-018 State: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL (reload) on simultaneous input and output transfer; FULL holds on no output transfer.
REQ-019 While FULL and out_ready=0, binary_output and onehot_error SHALL remain stable, and in_ready SHALL be 0.
REQ-020 Exactly one bit k set: binary_output=k, onehot_error=0.
REQ-021 All-zero word: binary_output=0, onehot_error=1.
REQ-022 Multi-hot word: binary_output=index of lowest set bit, onehot_error=1.
REQ-023 onehot_input SHALL be ignored when in_valid=0 or in_ready=0; no register or counter change.
REQ-024 error_count SHALL increment by 1 on each input transfer with an illegal word, evaluated at acceptance, not at output.
REQ-025 error_count SHALL saturate at 2**count_width-1; further illegal words leave it unchanged.
REQ-026 clear_count=1 SHALL set error_count to 0 on that edge; clear wins over a simultaneous increment (that error is not counted).
REQ-027 All outputs other than in_ready SHALL be registered.

Reset
REQ-028 rst=1 SHALL immediately force out_valid=0, binary_output=0, onehot_error=0, error_count=0; in_ready therefore reads 1 during reset.
REQ-029 Reset mid-transaction SHALL discard the held word; no transfer is reported for it.
REQ-030 After rst deasserts, the first input transfer SHALL occur no earlier than the first rising edge with rst=0.

Verification (input_width=4, count_width=8)
REQ-031 Sweep: feed 16'h0001 << k, k=0..15, back-to-back with out_ready=1 -> binary_output=k one cycle later, onehot_error=0, in_ready held 1, error_count=0.
REQ-032 Illegal: accept 16'h0000 then 16'h0014 -> outputs (0,err=1) then (2,err=1); error_count=2.
REQ-033 Backpressure: accept 16'h0100, hold out_ready=0 for 5 cycles with in_valid=1, onehot_input=16'h0002 -> in_ready=0, binary_output stays 8; on out_ready=1, 8 transfers, then 1 next cycle.
REQ-034 Saturation/clear: 260 illegal words -> error_count=255; clear_count=1 on same edge as illegal accept -> error_count=0.
REQ-035 Reset mid-operation: assert rst while FULL with out_ready=0 and error_count=3 -> out_valid=0, error_count=0 immediately, no output transfer of the held word.
